// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch run/pause/lap/clear controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } sw_state_t;

    localparam int DEFAULT_TICK_DIV    = 1000000;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, saturation and digit-chain control signals of the stopwatch controller.
interface stopwatch_ctrl_if;

    logic       btn_startstop;
    logic       btn_lap;
    logic       btn_clear;
    logic       max_flag;
    logic       count_en;
    logic       count_clr;
    logic       display_hold;
    logic [1:0] state;

    modport master (
        output btn_startstop, btn_lap, btn_clear, max_flag,
        input  count_en, count_clr, display_hold, state
    );

    modport slave (
        input  btn_startstop, btn_lap, btn_clear, max_flag,
        output count_en, count_clr, display_hold, state
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_pulse.sv
// Synchronizes one raw button level into clk and emits a single-cycle pulse per press.
module btn_pulse
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    // Held buttons stay high in the synchronizer, so only the first sample yields a pulse.
    assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear FSM with tick prescaler driving the stopwatch digit chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave sw
);

    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    sw_state_t     st;
    logic [PW-1:0] presc;
    logic          en_q;
    logic          clr_q;
    logic          hold_q;
    logic          ss_p;
    logic          lap_p;
    logic          clr_p;
    logic          do_ss;
    logic          do_lap;
    logic          do_clr;
    logic          tick_due;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_ss  (.clk(clk), .reset(reset), .btn(sw.btn_startstop), .pulse(ss_p));
    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_lap (.clk(clk), .reset(reset), .btn(sw.btn_lap),       .pulse(lap_p));
    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_clr (.clk(clk), .reset(reset), .btn(sw.btn_clear),     .pulse(clr_p));

    // Only the highest-priority press of a cycle survives, even if the state then ignores it.
    assign do_clr   = clr_p;
    assign do_ss    = ss_p & ~clr_p;
    assign do_lap   = lap_p & ~ss_p & ~clr_p;
    assign tick_due = (presc == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= IDLE;
            presc  <= '0;
            en_q   <= 1'b0;
            clr_q  <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            clr_q <= 1'b0;
            case (st)
                IDLE: begin
                    presc <= '0;
                    if (do_ss) begin
                        st <= RUNNING;
                    end else if (do_clr) begin
                        clr_q <= 1'b1;
                    end
                end
                RUNNING, LAP: begin
                    // Pausing freezes the prescaler on this edge so a resume keeps the tick phase.
                    if (do_ss) begin
                        st     <= PAUSED;
                        hold_q <= 1'b0;
                    end else begin
                        presc <= tick_due ? '0 : presc + 1'b1;
                        if (tick_due && sw.max_flag) begin
                            st     <= PAUSED;
                            hold_q <= 1'b0;
                        end else begin
                            en_q <= tick_due;
                            if (do_lap) begin
                                st     <= (st == RUNNING) ? LAP : RUNNING;
                                hold_q <= (st == RUNNING);
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (do_ss) begin
                        st <= RUNNING;
                    end else if (do_clr) begin
                        st    <= IDLE;
                        presc <= '0;
                        clr_q <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign sw.state        = st;
    assign sw.count_en     = en_q;
    assign sw.count_clr    = clr_q;
    assign sw.display_hold = hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus random button traffic against a cycle-level model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int SYNC_STAGES = 2;
    localparam logic [2:0] B_NONE = 3'b000;
    localparam logic [2:0] B_SS   = 3'b001;
    localparam logic [2:0] B_LAP  = 3'b010;
    localparam logic [2:0] B_CLR  = 3'b100;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passes = 0;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw)
    );

    always #5 clk = ~clk;

    // Reference model: button history queue, total counted run cycles, abstract state.
    sw_state_t  m_state;
    logic       m_en, m_clr, m_hold;
    int         m_counted;
    logic [2:0] lvl_q[$];

    task automatic model_reset();
        m_state   = IDLE;
        m_en      = 1'b0;
        m_clr     = 1'b0;
        m_hold    = 1'b0;
        m_counted = 0;
        lvl_q     = {};
        for (int i = 0; i <= SYNC_STAGES; i++) lvl_q.push_back(3'b000);
    endtask

    task automatic model_step(input logic [2:0] btns, input logic mf);
        logic [2:0] rise;
        logic       p_ss, p_lap, p_clr, due;
        rise = lvl_q[1] & ~lvl_q[0];
        lvl_q.push_back(btns);
        void'(lvl_q.pop_front());
        p_clr = rise[2];
        p_ss  = rise[0] & ~p_clr;
        p_lap = rise[1] & ~rise[0] & ~p_clr;
        m_en  = 1'b0;
        m_clr = 1'b0;
        case (m_state)
            IDLE: begin
                if (p_ss) m_state = RUNNING;
                else if (p_clr) m_clr = 1'b1;
            end
            PAUSED: begin
                if (p_ss) m_state = RUNNING;
                else if (p_clr) begin
                    m_state   = IDLE;
                    m_counted = 0;
                    m_clr     = 1'b1;
                end
            end
            default: begin
                if (p_ss) begin
                    m_state = PAUSED;
                    m_hold  = 1'b0;
                end else begin
                    m_counted++;
                    due = ((m_counted % TICK_DIV) == 0);
                    if (due && mf) begin
                        m_state = PAUSED;
                        m_hold  = 1'b0;
                    end else begin
                        m_en = due;
                        if (p_lap) begin
                            m_hold  = (m_state == RUNNING);
                            m_state = (m_state == RUNNING) ? LAP : RUNNING;
                        end
                    end
                end
            end
        endcase
    endtask

    function automatic logic [4:0] dut_obs();
        return {sw.state, sw.count_en, sw.count_clr, sw.display_hold};
    endfunction

    function automatic logic [4:0] model_obs();
        return {m_state, m_en, m_clr, m_hold};
    endfunction

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic cycle(input logic [2:0] btns, input logic mf);
        sw.btn_startstop = btns[0];
        sw.btn_lap       = btns[1];
        sw.btn_clear     = btns[2];
        sw.max_flag      = mf;
        @(posedge clk);
        model_step(btns, mf);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_obs() !== 5'b00000) $display("[TB] FAIL reset_state: got %b expected 00000", dut_obs());
        else passes++;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_run_ticks();
        int first_en = -1;
        int en_cnt   = 0;
        for (int i = 1; i <= 3; i++) begin
            cycle(B_SS, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL start_press: got %b expected %b", dut_obs(), model_obs());
            else passes++;
        end
        checks++;
        if (sw.state !== RUNNING) $display("[TB] FAIL start_edge3: got %b expected 01", sw.state);
        else passes++;
        for (int i = 1; i <= 12; i++) begin
            cycle(B_NONE, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL run_ticks: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_en === 1'b1) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
            end
        end
        checks++;
        if (first_en != TICK_DIV) $display("[TB] FAIL first_tick: got %0d expected %0d", first_en, TICK_DIV);
        else passes++;
        checks++;
        if (en_cnt != 3) $display("[TB] FAIL tick_count: got %0d expected 3", en_cnt);
        else passes++;
    endtask

    task automatic test_pause_resume();
        int en_cnt   = 0;
        int gap;
        int first_en = -1;
        repeat ($urandom_range(1, 3)) cycle(B_NONE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(B_SS, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL pause_press: got %b expected %b", dut_obs(), model_obs());
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(B_NONE, 1'b0);
            if (sw.count_en === 1'b1) en_cnt++;
        end
        checks++;
        if (sw.state !== PAUSED || en_cnt != 0)
            $display("[TB] FAIL paused_frozen: got state=%b ticks=%0d expected state=10 ticks=0", sw.state, en_cnt);
        else passes++;
        gap = TICK_DIV - (m_counted % TICK_DIV);
        repeat (3) cycle(B_SS, 1'b0);
        for (int i = 1; i <= TICK_DIV + 1; i++) begin
            cycle(B_NONE, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL resume: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_en === 1'b1 && first_en < 0) first_en = i;
        end
        checks++;
        if (first_en != gap) $display("[TB] FAIL resume_phase: got %0d expected %0d", first_en, gap);
        else passes++;
    endtask

    task automatic test_lap();
        int en_cnt = 0;
        repeat (3) cycle(B_LAP, 1'b0);
        checks++;
        if (sw.state !== LAP || sw.display_hold !== 1'b1)
            $display("[TB] FAIL lap_enter: got state=%b hold=%b expected state=11 hold=1", sw.state, sw.display_hold);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            cycle(B_NONE, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL lap_run: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_en === 1'b1) en_cnt++;
        end
        checks++;
        if (en_cnt != 2) $display("[TB] FAIL lap_ticks: got %0d expected 2", en_cnt);
        else passes++;
        repeat (3) cycle(B_LAP, 1'b0);
        checks++;
        if (sw.state !== RUNNING || sw.display_hold !== 1'b0)
            $display("[TB] FAIL lap_exit: got state=%b hold=%b expected state=01 hold=0", sw.state, sw.display_hold);
        else passes++;
    endtask

    task automatic test_clear();
        int clr_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cycle((i < 3) ? B_CLR : B_NONE, 1'b0);
            if (sw.count_clr === 1'b1) clr_cnt++;
        end
        checks++;
        if (clr_cnt != 0 || sw.state !== RUNNING)
            $display("[TB] FAIL clear_running: got clr=%0d state=%b expected clr=0 state=01", clr_cnt, sw.state);
        else passes++;
        repeat (3) cycle(B_SS, 1'b0);
        repeat (2) cycle(B_NONE, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle((i < 3) ? B_CLR : B_NONE, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL clear_paused: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_clr === 1'b1) clr_cnt++;
        end
        checks++;
        if (clr_cnt != 1 || sw.state !== IDLE)
            $display("[TB] FAIL clear_pulse: got clr=%0d state=%b expected clr=1 state=00", clr_cnt, sw.state);
        else passes++;
    endtask

    task automatic test_priority();
        int clr_cnt = 0;
        int en_cnt  = 0;
        repeat (3) cycle(B_SS, 1'b0);
        repeat (2) cycle(B_NONE, 1'b0);
        repeat (3) cycle(B_SS, 1'b0);
        cycle(B_NONE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(3'b111, 1'b0);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL priority_hold: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_clr === 1'b1) clr_cnt++;
            if (sw.count_en === 1'b1) en_cnt++;
        end
        checks++;
        if (clr_cnt != 1 || en_cnt != 0 || sw.state !== IDLE)
            $display("[TB] FAIL priority: got clr=%0d en=%0d state=%b expected clr=1 en=0 state=00", clr_cnt, en_cnt, sw.state);
        else passes++;
        repeat (2) cycle(B_NONE, 1'b0);
    endtask

    task automatic test_saturation();
        int en_cnt = 0;
        repeat (3) cycle(B_SS, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(B_NONE, 1'b1);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL saturate: got %b expected %b", dut_obs(), model_obs());
            else passes++;
            if (sw.count_en === 1'b1) en_cnt++;
        end
        checks++;
        if (en_cnt != 0 || sw.state !== PAUSED)
            $display("[TB] FAIL saturate_stop: got en=%0d state=%b expected en=0 state=10", en_cnt, sw.state);
        else passes++;
    endtask

    task automatic test_async_reset();
        repeat (3) cycle(B_SS, 1'b0);
        repeat (3) cycle(B_LAP, 1'b0);
        repeat (2) cycle(B_NONE, 1'b0);
        checks++;
        if (sw.state !== LAP || sw.display_hold !== 1'b1)
            $display("[TB] FAIL lap_setup: got state=%b hold=%b expected state=11 hold=1", sw.state, sw.display_hold);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_obs() !== 5'b00000) $display("[TB] FAIL async_reset: got %b expected 00000", dut_obs());
        else passes++;
        model_reset();
        @(negedge clk);
        checks++;
        if (dut_obs() !== 5'b00000) $display("[TB] FAIL reset_held: got %b expected 00000", dut_obs());
        else passes++;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] lv = 3'b000;
        logic       mf;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) lv[b] = ~lv[b];
            mf = ($urandom_range(0, 15) == 0);
            cycle(lv, mf);
            checks++;
            if (dut_obs() !== model_obs()) $display("[TB] FAIL random_%0d: got %b expected %b", i, dut_obs(), model_obs());
            else passes++;
        end
    endtask

    initial begin
        sw.btn_startstop = 1'b0;
        sw.btn_lap       = 1'b0;
        sw.btn_clear     = 1'b0;
        sw.max_flag      = 1'b0;
        model_reset();
        test_reset();
        test_run_ticks();
        test_pause_resume();
        test_lap();
        test_clear();
        test_priority();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
